// File: rtl/fetch_pc_pkg.sv
// fetch_pc_pkg: FSM states, next-PC select encodings and default reset PC
package fetch_pc_pkg;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h4000_0000;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_BOOT  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        NPC_RESET = 3'd0,
        NPC_EX    = 3'd1,
        NPC_HOLD  = 3'd2,
        NPC_DEC   = 3'd3,
        NPC_SEQ   = 3'd4
    } npc_sel_e;
endpackage

// File: rtl/fetch_npc_mux.sv
// fetch_npc_mux: priority select of the next fetch address and its source
module fetch_npc_mux
    import fetch_pc_pkg::*;
(
    input  logic        run,
    input  logic        stall,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    input  logic        dec_target_taken,
    input  logic [31:0] dec_target,
    input  logic [31:0] pc,
    input  logic [31:0] reset_pc,
    output logic [31:0] npc,
    output npc_sel_e    sel
);
    // Redirect targets are word-aligned by dropping bits [1:0]
    always_comb begin
        sel = !run ? NPC_RESET : ex_redirect ? NPC_EX : stall ? NPC_HOLD :
              dec_target_taken ? NPC_DEC : NPC_SEQ;
        npc = sel == NPC_RESET ? reset_pc :
              sel == NPC_EX    ? {ex_redirect_pc[31:2], 2'b00} :
              sel == NPC_HOLD  ? pc :
              sel == NPC_DEC   ? {dec_target[31:2], 2'b00} : pc + 32'd4;
    end
endmodule

// File: rtl/fetch_pc.sv
// fetch_pc: fetch-stage PC register, boot FSM, valid tagging and redirect stats
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic [31:0] dec_target,
    input  logic        dec_target_taken,
    input  logic        ex_redirect,
    input  logic [31:0] ex_redirect_pc,
    output logic [31:0] imem_addr,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        misaligned,
    output logic [31:0] n_dec_redirect,
    output logic [31:0] n_ex_redirect
);
    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d, npc;
    logic [31:0] nd_q, nd_d, ne_q, ne_d;
    logic        mis_q, mis_d;
    npc_sel_e    sel;

    fetch_npc_mux u_mux (
        .run             (state_q == ST_RUN && !rst),
        .stall           (stall),
        .ex_redirect     (ex_redirect),
        .ex_redirect_pc  (ex_redirect_pc),
        .dec_target_taken(dec_target_taken),
        .dec_target      (dec_target),
        .pc              (pc_q),
        .reset_pc        (RESET_PC),
        .npc             (npc),
        .sel             (sel)
    );

    // RESET while rst is high, one BOOT cycle, then RUN
    always_comb state_d = rst ? ST_RESET : state_q == ST_RESET ? ST_BOOT : ST_RUN;

    // PC follows next-PC every cycle; flags and counters track accepted redirects
    always_comb begin
        pc_d  = npc;
        mis_d = mis_q | (sel == NPC_EX && ex_redirect_pc[1:0] != 2'b00)
                      | (sel == NPC_DEC && dec_target[1:0] != 2'b00);
        nd_d  = nd_q + {31'd0, sel == NPC_DEC};
        ne_d  = ne_q + {31'd0, sel == NPC_EX};
    end

    // State register and datapath flops
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RESET;
            pc_q    <= RESET_PC;
            mis_q   <= 1'b0;
            nd_q    <= 32'd0;
            ne_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            mis_q   <= mis_d;
            nd_q    <= nd_d;
            ne_q    <= ne_d;
        end
    end

    // An execute redirect kills the wrong-path instruction in decode
    always_comb begin
        if_valid       = state_q == ST_RUN && !ex_redirect;
        imem_addr      = npc;
        if_pc          = pc_q;
        misaligned     = mis_q;
        n_dec_redirect = nd_q;
        n_ex_redirect  = ne_q;
    end
endmodule
